// File: rtl/host_cmd_deframer.sv
// host_cmd_deframer: hunts a sync byte in the host byte stream and
// assembles big-endian command/address/data words for wishbone_master.
module host_cmd_deframer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hCD,
  parameter int          TIMEOUT   = 1000,
  parameter logic [15:0] WR_OPCODE = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic        master_ready,
  output logic        in_ready,
  output logic [31:0] in_command,
  output logic [31:0] in_address,
  output logic [31:0] in_data,
  output logic        frame_error,
  output logic        busy
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ISSUE,
    DATA,
    DISPATCH
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     byte_cnt;
  logic [15:0]    words_left;
  logic [15:0]    wl_dec;
  logic [GW-1:0]  gap;
  logic [87:0]    sh;
  logic [95:0]    sh_nxt;
  logic           take;
  logic           expire;
  logic           collecting;
  logic           hdr_done;
  logic           dat_done;

  // Bytes land in a shadow register; outputs only load on a complete word
  always_comb begin
    state_nxt    = state;
    byte_ready_o = 1'b0;
    in_ready     = 1'b0;
    collecting   = 1'b0;
    unique case (state)
      IDLE:           byte_ready_o = rst;
      HDR, DATA: begin
        byte_ready_o = rst;
        collecting   = 1'b1;
      end
      ISSUE, DISPATCH: in_ready = rst & master_ready;
      default: ;
    endcase
    take     = byte_valid_i & byte_ready_o;
    expire   = collecting & ~take & (gap == GAP_LAST);
    hdr_done = take & (state == HDR) & (byte_cnt == 4'd11);
    dat_done = take & (state == DATA) & (byte_cnt == 4'd3);
    wl_dec   = words_left - 16'd1;
    sh_nxt   = {sh, byte_i};
    unique case (state)
      IDLE:
        if (take && byte_i == SYNC_BYTE) state_nxt = HDR;
      HDR:
        if (hdr_done)    state_nxt = ISSUE;
        else if (expire) state_nxt = IDLE;
      DATA:
        if (dat_done)    state_nxt = DISPATCH;
        else if (expire) state_nxt = IDLE;
      ISSUE:
        if (in_ready)
          state_nxt = (in_command[15:0] == WR_OPCODE && wl_dec != 16'd0)
                      ? DATA : IDLE;
      DISPATCH:
        if (in_ready) state_nxt = (wl_dec == 16'd0) ? IDLE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      words_left  <= '0;
      gap         <= '0;
      sh          <= '0;
      frame_error <= 1'b0;
      in_command  <= '0;
      in_address  <= '0;
      in_data     <= '0;
    end else begin
      state       <= state_nxt;
      frame_error <= expire;
      if (!collecting || take || expire) gap <= '0;
      else if (gap != GAP_MAX)           gap <= gap + 1'b1;
      if (take) begin
        sh <= sh_nxt[87:0];
        if (state != IDLE) byte_cnt <= byte_cnt + 4'd1;
      end
      if (hdr_done) begin
        in_command <= sh_nxt[95:64];
        in_address <= sh_nxt[63:32];
        in_data    <= sh_nxt[31:0];
        words_left <= (sh_nxt[95:80] == 16'd0) ? 16'd1 : sh_nxt[95:80];
      end
      if (dat_done) in_data <= sh_nxt[31:0];
      if (in_ready) begin
        words_left <= wl_dec;
        byte_cnt   <= '0;
      end
      if (expire) begin
        words_left <= '0;
        byte_cnt   <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_host_cmd_deframer.sv
// tb_host_cmd_deframer: directed and random frames checked against a
// frame-level model of the expected word sequence.
module tb_host_cmd_deframer;

  localparam int TO = 50;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        master_ready;
  logic        in_ready;
  logic [31:0] in_command;
  logic [31:0] in_address;
  logic [31:0] in_data;
  logic        frame_error;
  logic        busy;

  logic mr_fix = 1'b1;
  logic mr_rand_en = 1'b0;
  logic mr_r = 1'b1;
  assign master_ready = mr_rand_en ? mr_r : mr_fix;

  int n_vec = 0;
  int n_bad = 0;
  int n_rdy = 0;
  int n_err = 0;
  word_t exp_q[$];
  logic [31:0] xw[$];
  word_t mw;

  host_cmd_deframer #(
    .SYNC_BYTE(8'hCD),
    .TIMEOUT(TO),
    .WR_OPCODE(16'h0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .master_ready(master_ready),
    .in_ready(in_ready),
    .in_command(in_command),
    .in_address(in_address),
    .in_data(in_data),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    mr_r = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (frame_error) n_err++;
    if (in_ready) begin
      n_rdy++;
      if (exp_q.size() == 0) begin
        chk("spurious_rdy", 32'(in_ready), 32'd0);
      end else begin
        mw = exp_q.pop_front();
        chk("word_cmd", in_command, mw.c);
        chk("word_addr", in_address, mw.a);
        chk("word_data", in_data, mw.d);
      end
    end
  end

  function automatic int nwords(input logic [31:0] c);
    if (c[15:0] != 16'h0001) return 1;
    return (c[31:16] == 16'd0) ? 1 : int'(c[31:16]);
  endfunction

  task automatic model_frame(input logic [31:0] c, a, d);
    word_t w;
    w.c = c;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
    for (int i = 1; i < nwords(c); i++) begin
      w.d = xw[i-1];
      exp_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    int n = 0;
    if (idle > 0) begin
      repeat (idle) @(posedge clk);
      #1;
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    @(negedge clk);
    while (!byte_ready_o && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready_o) chk("byte_stall", 32'(byte_ready_o), 32'd1);
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxidle);
    for (int i = 0; i < 4; i++)
      send_byte(w[31-8*i -: 8], $urandom_range(0, maxidle));
  endtask

  task automatic send_hdr(input logic [31:0] c, a, d, input int maxidle);
    send_byte(8'hCD, $urandom_range(0, maxidle));
    send_word(c, maxidle);
    send_word(a, maxidle);
    send_word(d, maxidle);
  endtask

  task automatic send_frame(input logic [31:0] c, a, d, input int maxidle);
    model_frame(c, a, d);
    send_hdr(c, a, d, maxidle);
    for (int i = 1; i < nwords(c); i++) send_word(xw[i-1], maxidle);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("idle_wait", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int eb;
    int total;
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] d;
    logic ok;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bready", 32'(byte_ready_o), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_cmd", in_command, 32'd0);
    chk("rst_addr", in_address, 32'd0);
    chk("rst_data", in_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_bready", 32'(byte_ready_o), 32'd1);
    @(posedge clk);
    #1;

    base = n_rdy;
    send_frame(32'h00000002, 32'h00000100, 32'h00000000, 0);
    wait_idle();
    chk("read_pulses", n_rdy - base, 32'd1);

    base = n_rdy;
    xw = {32'h22222222, 32'h33333333};
    c = 32'h00030001;
    a = 32'h01000000;
    d = 32'h11111111;
    model_frame(c, a, d);
    send_hdr(c, a, d, 0);
    @(negedge clk);
    chk("wr_first_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 mr_fix = 1'b0;
    send_word(xw[0], 0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (byte_ready_o || in_ready) ok = 1'b0;
    end
    chk("bp_hold", 32'(ok), 32'd1);
    @(posedge clk);
    #1 mr_fix = 1'b1;
    @(negedge clk);
    chk("bp_fire", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_word(xw[1], 0);
    wait_idle();
    chk("wr_pulses", n_rdy - base, 32'd3);

    base = n_rdy;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 0);
    send_frame(32'hCDCD00CD, 32'hCDCDCDCD, 32'h0000CD00, 1);
    wait_idle();
    chk("noise_pulses", n_rdy - base, 32'd1);

    base = n_rdy;
    eb = n_err;
    model_frame(32'h00000004, 32'h00000040, 32'h12345678);
    send_byte(8'hCD, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, TO - 1);
    send_byte(8'h04, 0);
    send_word(32'h00000040, 0);
    send_word(32'h12345678, 0);
    wait_idle();
    chk("late_byte_err", n_err - eb, 32'd0);
    chk("late_byte_pulses", n_rdy - base, 32'd1);

    base = n_rdy;
    eb = n_err;
    send_byte(8'hCD, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h5A + 8'(i), 0);
    repeat (TO + 10) @(posedge clk);
    #1;
    chk("to_err", n_err - eb, 32'd1);
    chk("to_rdy", n_rdy - base, 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_hold_cmd", in_command, 32'h00000004);
    chk("to_hold_data", in_data, 32'h12345678);
    send_frame(32'h00000009, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    wait_idle();
    chk("to_next_pulses", n_rdy - base, 32'd1);

    base = n_rdy;
    eb = n_err;
    xw = {32'hAAAA5555};
    c = 32'h00020001;
    model_frame(c, 32'h00000200, 32'h0BADF00D);
    send_hdr(c, 32'h00000200, 32'h0BADF00D, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hAA, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd", in_command, 32'd0);
    chk("mid_rst_addr", in_address, 32'd0);
    chk("mid_rst_data", in_data, 32'd0);
    chk("mid_rst_bready", 32'(byte_ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_rst_pulses", n_rdy - base, 32'd1);
    chk("mid_rst_err", n_err - eb, 32'd0);
    send_frame(32'h00000003, 32'h00000300, 32'h00C0FFEE, 0);
    wait_idle();
    chk("mid_rst_next", n_rdy - base, 32'd2);

    mr_rand_en = 1'b1;
    base = n_rdy;
    total = 0;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < $urandom_range(0, 2); k++)
        send_byte(8'($urandom_range(0, 8'hCC)), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        c = {16'($urandom_range(0, 3)), 16'h0001};
      end else begin
        c = $urandom;
        if (c[15:0] == 16'h0001) c[15:0] = 16'h0002;
      end
      xw.delete();
      for (int i = 1; i < nwords(c); i++) xw.push_back($urandom);
      total += nwords(c);
      send_frame(c, $urandom, $urandom, 2);
      wait_idle();
    end
    chk("rand_pulses", n_rdy - base, total);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
